// File: rtl/cdc_hs_arbiter_pkg.sv
// Shared definitions for the CDC handshake arbiter: FSM state encoding,
// default parameter values and an index-width helper.
package cdc_hs_arbiter_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DW     = 32;
    localparam int DEF_TO_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REQ_HI      = 2'd1,
        ST_ACK_WAIT_LO = 2'd2
    } arb_state_e;

    // Bits needed to hold an index in 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing a level signal from another clock
// domain into clk_i. Both stages clear on reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back stages; only the second stage is used downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter feeding a 4-phase CDC handshake sender. One transfer
// is in flight at a time; the handshake must fully close (ack seen low)
// before the next requester is granted. A missing ack times out.
module cdc_hs_arbiter
    import cdc_hs_arbiter_pkg::*;
#(
    parameter int  N_REQ  = DEF_N_REQ,
    parameter int  DW     = DEF_DW,
    parameter int  TO_CYC = DEF_TO_CYC,
    localparam int GW     = idx_width(N_REQ)
) (
    input  logic              t_clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]  req_ready,
    output logic              hs_req,
    output logic [DW-1:0]     hs_data,
    input  logic              hs_ack,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int CW = idx_width(TO_CYC);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hs_req_q, hs_req_d;
    logic [DW-1:0] hs_data_q, hs_data_d;
    logic [GW-1:0] gid_q, gid_d;
    logic          armed_q;
    logic          ack_s;

    logic [GW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic [GW-1:0]    win_idx;
    logic             win_found;
    logic             grant_fire;

    // The receiver-domain ack is only ever looked at through this synchronizer.
    sync_2ff #(
        .W (1)
    ) u_ack_sync (
        .clk_i  (t_clk),
        .rst_ni (rst_n),
        .d_i    (hs_ack),
        .q_o    (ack_s)
    );

    // Candidate k is the requester k positions after the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [GW:0] sum;
            assign sum           = {1'b0, rr_q} + (GW+1)'(gi);
            assign cand_idx[gi]  = (sum >= (GW+1)'(N_REQ)) ? GW'(sum - (GW+1)'(N_REQ))
                                                           : GW'(sum);
            assign cand_hit[gi]  = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Pick the first active candidate, i.e. the nearest requester at or after rr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    // One-hot acceptance pulse, only in the cycle a grant is actually taken.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_fire && (win_idx == GW'(gi));
        end
    endgenerate

    // Next-state and pulse outputs for the three-state handshake FSM.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        hs_req_d    = hs_req_q;
        hs_data_d   = hs_data_q;
        gid_d       = gid_q;
        grant_fire  = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // armed_q holds off grants until the first edge after reset.
                if (armed_q && win_found) begin
                    grant_fire = 1'b1;
                    hs_data_d  = req_data[win_idx*DW +: DW];
                    gid_d      = win_idx;
                    hs_req_d   = 1'b1;
                    cnt_d      = '0;
                    rr_d       = (win_idx == GW'(N_REQ - 1)) ? '0 : win_idx + GW'(1);
                    state_d    = ST_REQ_HI;
                end
            end
            ST_REQ_HI: begin
                // An ack arriving on the last allowed cycle still counts as success.
                if (ack_s) begin
                    done     = 1'b1;
                    hs_req_d = 1'b0;
                    state_d  = ST_ACK_WAIT_LO;
                end else if (cnt_q == CW'(TO_CYC - 1)) begin
                    timeout_err = 1'b1;
                    hs_req_d    = 1'b0;
                    state_d     = ST_ACK_WAIT_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACK_WAIT_LO: begin
                // Wait for the receiver to drop ack so phases never overlap.
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            cnt_q     <= '0;
            hs_req_q  <= 1'b0;
            hs_data_q <= '0;
            gid_q     <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            hs_req_q  <= hs_req_d;
            hs_data_q <= hs_data_d;
            gid_q     <= gid_d;
            armed_q   <= 1'b1;
        end
    end

    assign hs_req   = hs_req_q;
    assign hs_data  = hs_data_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Self-checking bench for cdc_hs_arbiter: a transaction-level model checks
// every output on every falling edge, directed scenarios pin literal results,
// and a randomized phase exercises requests, ack timing, timeouts and reset.
module tb_cdc_hs_arbiter;
    import cdc_hs_arbiter_pkg::*;

    localparam int N  = DEF_N_REQ;
    localparam int DW = DEF_DW;
    localparam int TO = DEF_TO_CYC;
    localparam int GW = idx_width(N);

    logic            t_clk;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            hs_ack = 1'b0;
    logic [N-1:0]    req_ready;
    logic            hs_req;
    logic [DW-1:0]   hs_data;
    logic [GW-1:0]   grant_id;
    logic            busy, done, timeout_err;

    cdc_hs_arbiter #(.N_REQ(N), .DW(DW), .TO_CYC(TO)) dut (
        .t_clk       (t_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .hs_req      (hs_req),
        .hs_data     (hs_data),
        .hs_ack      (hs_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model state (transaction level) ----------------
    bit          m_serving, m_closing, m_live;
    int          m_age, m_gid, m_rr;
    logic [DW-1:0] m_data;
    logic        m_s1, m_s2;     // ack as seen after one / two t_clk edges

    // ---------------- monitor logs ----------------
    int            g_id_q[$];
    logic [DW-1:0] g_data_q[$];
    int grants = 0, done_cnt = 0, to_cnt = 0;
    int rise_cyc = 0, last_done_cyc = 0, last_to_cyc = 0;
    bit prev_hs = 1'b0;
    logic [N-1:0] acc_mask = '0;

    function automatic int rr_pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int log_id(input int k);
        if (k < g_id_q.size()) return g_id_q[k];
        return -1;
    endfunction

    function automatic logic [DW-1:0] log_data(input int k);
        if (k < g_data_q.size()) return g_data_q[k];
        return 'x;
    endfunction

    // Compare every output against the model, log transactions, then advance
    // the model over the coming rising edge using the inputs now applied.
    always @(negedge t_clk) begin
        int w;
        logic [N-1:0] exp_ready;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_hs_req", hs_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_timeout", timeout_err, 0);
            chk("rst_hs_data", hs_data, 0);
            chk("rst_grant_id", grant_id, 0);
            m_serving = 0; m_closing = 0; m_live = 0;
            m_age = 0; m_rr = 0; m_gid = 0; m_data = '0;
            m_s1 = 0; m_s2 = 0;
            acc_mask = '0;
            prev_hs = 1'b0;
        end else begin
            w = (!m_serving && !m_closing && m_live) ? rr_pick(req_valid, m_rr) : -1;
            exp_ready = (w >= 0) ? N'(1 << w) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("hs_req", hs_req, m_serving);
            chk("busy", busy, m_serving || m_closing);
            chk("done", done, m_serving && m_s2);
            chk("timeout_err", timeout_err, m_serving && !m_s2 && (m_age == TO - 1));
            if (m_serving) begin
                chk("hs_data", hs_data, m_data);
                chk("grant_id", grant_id, m_gid);
            end
            if (hs_req && !prev_hs) begin
                g_id_q.push_back(int'(grant_id));
                g_data_q.push_back(hs_data);
                grants++;
                rise_cyc = cyc;
                $display("txn %0d: grant id=%0d data=%08h cycle=%0d", grants, grant_id, hs_data, cyc);
            end
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (timeout_err) begin to_cnt++; last_to_cyc = cyc; end
            prev_hs = hs_req;
            acc_mask = req_ready;
            // advance the model
            if (w >= 0) begin
                m_serving = 1; m_age = 0; m_gid = w;
                m_data = req_data[w*DW +: DW];
                m_rr = (w + 1) % N;
            end else if (m_serving) begin
                if (m_s2 || m_age == TO - 1) begin
                    m_serving = 0; m_closing = 1;
                end else begin
                    m_age++;
                end
            end else if (m_closing) begin
                if (!m_s2) m_closing = 0;
            end
            m_live = 1;
            m_s2 = m_s1;
            m_s1 = hs_ack;
        end
    end

    // ---------------- stimulus: requesters and ack responder ----------------
    bit rand_req = 0;
    logic [N-1:0] keep_mask = '0, pend_mask = '0;
    bit ack_en = 0;
    int ack_delay = 6, ack_hold = 2;
    int rsp_st = 0, rsp_cnt = 0;

    task automatic tick();
        @(posedge t_clk);
        #1;
        req_valid = (req_valid & ~acc_mask) | pend_mask | keep_mask;
        pend_mask = '0;
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_data[i*DW +: DW] = $urandom;
                    req_valid[i] = 1'b1;
                end
            end
        end
        case (rsp_st)
            0: if (hs_req && ack_en) begin
                   if (ack_delay == 0) begin hs_ack = 1'b1; rsp_st = 2; end
                   else begin rsp_cnt = 1; rsp_st = 1; end
               end
            1: if (!hs_req) rsp_st = 0;
               else if (rsp_cnt >= ack_delay) begin hs_ack = 1'b1; rsp_st = 2; end
               else rsp_cnt++;
            2: if (!hs_req) begin rsp_cnt = 0; rsp_st = 3; end
            3: if (rsp_cnt >= ack_hold) begin hs_ack = 1'b0; rsp_st = 0; end
               else rsp_cnt++;
            default: rsp_st = 0;
        endcase
    endtask

    task automatic wait_grants(input int target, input int lim);
        for (int k = 0; k < lim && grants < target; k++) tick();
        chk("wait_grant", grants >= target, 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int k = 0; k < lim && (busy || hs_ack || req_valid != 0 || rsp_st != 0); k++) tick();
        chk("wait_idle", busy || hs_ack || req_valid != 0 || rsp_st != 0, 0);
    endtask

    logic [DW-1:0] pats [N] = '{32'hffff0000, 32'hff00ff00, 32'hf0f0f0f0, 32'hcccccccc};
    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        int base_g, base_d, base_t;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_hs_req", hs_req, 0);
        chk("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single transfer from requester 0, ack 6 cycles after hs_req.
        ack_en = 1; ack_delay = 6; ack_hold = 2;
        base_g = grants; base_d = done_cnt; base_t = to_cnt;
        req_data[0 +: DW] = 32'hf0f0f0f0;
        pend_mask = 4'b0001;
        wait_grants(base_g + 1, 20);
        wait_idle(100);
        chk("single_id", log_id(base_g), 0);
        chk("single_data", log_data(base_g), 32'hf0f0f0f0);
        chk("single_done", done_cnt - base_d, 1);
        chk("single_no_to", to_cnt - base_t, 0);
        chk("single_busy_end", busy, 0);

        // Fairness with all four held, starting from a fresh pointer.
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pats[i];
        ack_delay = 2; ack_hold = 1;
        base_g = grants;
        keep_mask = 4'b1111;
        wait_grants(base_g + 5, 200);
        keep_mask = '0;
        req_valid = '0;
        wait_idle(60);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", log_id(base_g + k), rr_order[k]);
            chk("rr_payload", log_data(base_g + k), pats[rr_order[k]]);
        end

        // Pointer wrap: grant 3, then 1001 must go to 0 first.
        base_g = grants;
        req_data[3*DW +: DW] = 32'h33333333;
        req_data[0 +: DW]    = 32'h0a0a0a0a;
        pend_mask = 4'b1000;
        wait_grants(base_g + 1, 30);
        pend_mask = 4'b1001;
        wait_grants(base_g + 3, 100);
        wait_idle(60);
        chk("wrap_first", log_id(base_g), 3);
        chk("wrap_next", log_id(base_g + 1), 0);
        chk("wrap_next_data", log_data(base_g + 1), 32'h0a0a0a0a);
        chk("wrap_third", log_id(base_g + 2), 3);

        // Timeout with no ack at all.
        ack_en = 0;
        base_g = grants; base_d = done_cnt; base_t = to_cnt;
        req_data[2*DW +: DW] = 32'h5a5a5a5a;
        pend_mask = 4'b0100;
        for (int k = 0; k < 150 && to_cnt == base_t; k++) tick();
        chk("to_count", to_cnt - base_t, 1);
        chk("to_latency", last_to_cyc - rise_cyc, TO - 1);
        chk("to_no_done", done_cnt - base_d, 0);
        chk("to_id", log_id(base_g), 2);
        tick();
        chk("to_hs_drop", hs_req, 0);
        wait_idle(20);

        // Reset while hs_req is high.
        base_g = grants; base_d = done_cnt; base_t = to_cnt;
        pend_mask = 4'b0001;
        wait_grants(base_g + 1, 20);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_hs_req", hs_req, 0);
        chk("rst_async_busy", busy, 0);
        req_valid = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        base_g = grants;
        pend_mask = 4'b0010;
        wait_grants(base_g + 1, 20);
        chk("post_rst_id", log_id(base_g), 1);
        chk("rst_no_done", done_cnt - base_d, 0);
        chk("rst_no_to", to_cnt - base_t, 0);
        ack_en = 1; ack_delay = 1; ack_hold = 0;
        wait_idle(40);

        // Ack held high for 20 cycles after done: no new grant meanwhile.
        ack_delay = 3; ack_hold = 20;
        base_g = grants; base_d = done_cnt;
        pend_mask = 4'b0001;
        for (int k = 0; k < 40 && done_cnt == base_d; k++) tick();
        chk("ackhold_done", done_cnt - base_d, 1);
        pend_mask = 4'b0100;
        wait_grants(base_g + 2, 100);
        chk("ackhold_gap", (rise_cyc - last_done_cyc) >= 22, 1);
        chk("ackhold_id", log_id(base_g + 1), 2);
        wait_idle(80);

        // Randomized phase: random requests, ack timing, missing acks, resets.
        base_g = grants;
        rand_req = 1;
        for (int seg = 0; seg < 30; seg++) begin
            ack_delay = $urandom_range(0, 8);
            ack_hold  = $urandom_range(0, 4);
            ack_en    = ($urandom_range(9) != 0);
            if ($urandom_range(9) == 0) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
            end
            repeat (100) tick();
        end
        rand_req = 0;
        req_valid = '0;
        ack_en = 1;
        wait_idle(200);
        chk("random_grants", grants > base_g, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
